// File: rtl/sync_fifo_flex.sv
// rtl/sync_fifo_flex.sv - single-clock FIFO with fill count, thresholds, sticky errors, flush and FWFT
module sync_fifo_flex #(
    parameter int Data_Width = 8,
    parameter int Depth      = 256,
    parameter int Addr_Width = 8,
    parameter int AF_Thresh  = 252,
    parameter int AE_Thresh  = 4,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [Data_Width-1:0] data_in,
    input  logic                  rd_en,
    output logic [Data_Width-1:0] data_out,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [Addr_Width:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [Addr_Width:0] DEPTH_CNT = (Addr_Width+1)'(Depth);
    localparam logic [Addr_Width:0] AF_CNT    = (Addr_Width+1)'(AF_Thresh);
    localparam logic [Addr_Width:0] AE_CNT    = (Addr_Width+1)'(AE_Thresh);

    logic [Data_Width-1:0] mem [Depth];
    logic [Addr_Width:0]   wr_ptr;
    logic [Addr_Width:0]   rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Flags come only from the registered pointers, never from wr_en/rd_en.
    assign count        = wr_ptr - rd_ptr;
    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

    assign wr_acc = wr_en && !full && !clear;
    assign rd_acc = rd_en && !empty && !clear;

    // Storage is intentionally left out of reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[Addr_Width-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_std
            logic [Data_Width-1:0] data_q;
            logic                  valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else if (clear) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        data_q <= mem[rd_ptr[Addr_Width-1:0]];
                    end
                end
            end

            assign data_out = data_q;
            assign rd_valid = valid_q;
        end else begin : g_fwft
            // Head is shown directly; forced to zero while empty so stale entries never leak.
            assign data_out = empty ? '0 : mem[rd_ptr[Addr_Width-1:0]];
            assign rd_valid = !empty;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb/tb_sync_fifo_flex.sv - scoreboard bench for sync_fifo_flex in standard and FWFT modes
module tb_sync_fifo_flex;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       s_clear = 0, s_wr_en = 0, s_rd_en = 0;
    logic [7:0] s_data_in = 0, s_data_out;
    logic       s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [3:0] s_count;

    logic       f_clear = 0, f_wr_en = 0, f_rd_en = 0;
    logic [7:0] f_data_in = 0, f_data_out;
    logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [3:0] f_count;

    sync_fifo_flex #(.Data_Width(8), .Depth(8), .Addr_Width(3), .AF_Thresh(6), .AE_Thresh(1), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .clear(s_clear), .wr_en(s_wr_en), .data_in(s_data_in), .rd_en(s_rd_en),
        .data_out(s_data_out), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo_flex #(.Data_Width(8), .Depth(8), .Addr_Width(3), .AF_Thresh(6), .AE_Thresh(1), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .clear(f_clear), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
        .data_out(f_data_out), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] s_sb[$];
    logic [7:0] f_sb[$];
    int         s_mcount = 0, f_mcount = 0;
    logic       s_movf = 0, s_mudf = 0, f_movf = 0, f_mudf = 0;
    logic       s_mvalid = 0;
    logic [7:0] s_mdout = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic reset_models();
        s_sb.delete(); f_sb.delete();
        s_mcount = 0; f_mcount = 0;
        s_movf = 0; s_mudf = 0; f_movf = 0; f_mudf = 0;
        s_mvalid = 0; s_mdout = 0;
    endtask

    task automatic check_std_flags();
        check("std_count", 32'(s_count), 32'(s_mcount));
        check("std_full", 32'(s_full), 32'(s_mcount == 8));
        check("std_empty", 32'(s_empty), 32'(s_mcount == 0));
        check("std_af", 32'(s_af), 32'(s_mcount >= 6));
        check("std_ae", 32'(s_ae), 32'(s_mcount <= 1));
        check("std_ovf", 32'(s_ovf), 32'(s_movf));
        check("std_udf", 32'(s_udf), 32'(s_mudf));
    endtask

    task automatic check_fwft_flags();
        check("fwft_count", 32'(f_count), 32'(f_mcount));
        check("fwft_full", 32'(f_full), 32'(f_mcount == 8));
        check("fwft_empty", 32'(f_empty), 32'(f_mcount == 0));
        check("fwft_valid", 32'(f_rd_valid), 32'(f_mcount != 0));
        check("fwft_af", 32'(f_af), 32'(f_mcount >= 6));
        check("fwft_ae", 32'(f_ae), 32'(f_mcount <= 1));
        check("fwft_ovf", 32'(f_ovf), 32'(f_movf));
        check("fwft_udf", 32'(f_udf), 32'(f_mudf));
        if (f_sb.size() > 0) check("fwft_head", 32'(f_data_out), 32'(f_sb[0]));
    endtask

    task automatic std_step(input logic we, input logic [7:0] d, input logic re, input logic clr);
        logic wa, ra;
        s_wr_en = we; s_data_in = d; s_rd_en = re; s_clear = clr;
        wa = we && (s_mcount != 8);
        ra = re && (s_mcount != 0);
        if (clr) begin
            s_sb.delete(); s_mcount = 0; s_movf = 0; s_mudf = 0; s_mdout = 0; s_mvalid = 0;
        end else begin
            if (we && s_mcount == 8) s_movf = 1;
            if (re && s_mcount == 0) s_mudf = 1;
            s_mvalid = ra;
            if (ra) s_mdout = s_sb[0];
            if (wa) s_sb.push_back(d);
            s_mcount = s_mcount + int'(wa) - int'(ra);
        end
        @(posedge clk); #1;
        s_wr_en = 0; s_rd_en = 0; s_clear = 0;
        check("std_rd_valid", 32'(s_rd_valid), 32'(s_mvalid));
        if (s_rd_valid) begin
            if (s_sb.size() == 0) check("std_sb_nonempty", 32'(0), 32'(1));
            else check("std_pop", 32'(s_data_out), 32'(s_sb.pop_front()));
        end
        check("std_dout", 32'(s_data_out), 32'(s_mdout));
        check_std_flags();
    endtask

    task automatic fwft_step(input logic we, input logic [7:0] d, input logic re, input logic clr);
        logic wa, ra;
        f_wr_en = we; f_data_in = d; f_rd_en = re; f_clear = clr;
        wa = we && (f_mcount != 8);
        ra = re && (f_mcount != 0);
        if (clr) begin
            f_sb.delete(); f_mcount = 0; f_movf = 0; f_mudf = 0;
        end else begin
            if (we && f_mcount == 8) f_movf = 1;
            if (re && f_mcount == 0) f_mudf = 1;
            if (ra) void'(f_sb.pop_front());
            if (wa) f_sb.push_back(d);
            f_mcount = f_mcount + int'(wa) - int'(ra);
        end
        @(posedge clk); #1;
        f_wr_en = 0; f_rd_en = 0; f_clear = 0;
        check_fwft_flags();
    endtask

    initial begin
        reset_models();
        #2;
        check("rst_std_dout", 32'(s_data_out), 32'(0));
        check("rst_std_valid", 32'(s_rd_valid), 32'(0));
        check("rst_fwft_dout", 32'(f_data_out), 32'(0));
        check_std_flags();
        check_fwft_flags();
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // Fill 0x01..0x08, then overflow attempt with 0xAA, then drain.
        for (int i = 1; i <= 8; i++) std_step(1, 8'(i), 0, 0);
        std_step(1, 8'hAA, 0, 0);
        check("ovf_set", 32'(s_ovf), 32'(1));
        for (int i = 0; i < 8; i++) std_step(0, 8'h00, 1, 0);
        std_step(0, 8'h00, 0, 0);
        check("ovf_sticky", 32'(s_ovf), 32'(1));
        std_step(0, 8'h00, 0, 1);
        check("clear_ovf", 32'(s_ovf), 32'(0));

        // Simultaneous read and write while empty.
        std_step(1, 8'h55, 1, 0);
        check("udf_count", 32'(s_count), 32'(1));
        std_step(0, 8'h00, 1, 0);
        check("udf_data", 32'(s_data_out), 32'(8'h55));
        std_step(0, 8'h00, 0, 1);

        // Steady state at depth 4 with pointer wrap.
        for (int i = 0; i < 4; i++) std_step(1, 8'(8'h10 + i), 0, 0);
        for (int i = 0; i < 20; i++) std_step(1, 8'(8'h20 + i), 1, 0);
        for (int i = 0; i < 4; i++) std_step(0, 8'h00, 1, 0);

        // FWFT: data visible without rd_en; a single pop empties.
        fwft_step(1, 8'h3C, 0, 0);
        check("fwft_3c", 32'(f_data_out), 32'(8'h3C));
        check("fwft_3c_empty", 32'(f_empty), 32'(0));
        fwft_step(0, 8'h00, 1, 0);
        check("fwft_popped_empty", 32'(f_empty), 32'(1));
        fwft_step(1, 8'h11, 1, 0);
        fwft_step(0, 8'h00, 0, 1);

        // Random traffic on both modes.
        for (int i = 0; i < 400; i++) begin
            std_step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
            fwft_step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
        end

        // Asynchronous reset mid-burst, between clock edges.
        std_step(0, 8'h00, 0, 1);
        fwft_step(0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) begin
            std_step(1, 8'(8'h70 + i), i > 2, 0);
            fwft_step(1, 8'(8'h80 + i), 0, 0);
        end
        #2; rst = 1; #1;
        reset_models();
        check("arst_std_dout", 32'(s_data_out), 32'(0));
        check("arst_std_valid", 32'(s_rd_valid), 32'(0));
        check("arst_fwft_dout", 32'(f_data_out), 32'(0));
        check_std_flags();
        check_fwft_flags();
        @(negedge clk); rst = 0;
        std_step(1, 8'h99, 0, 0);
        std_step(0, 8'h00, 1, 0);
        check("post_rst_data", 32'(s_data_out), 32'(8'h99));
        fwft_step(1, 8'h9A, 0, 0);
        check("post_rst_fwft", 32'(f_data_out), 32'(8'h9A));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Parametrised single-clock FIFO, successor to the team's dual-clock FIFO. Generalises width and depth, adds fill count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. Adds a synchronous flush and a selectable first-word-fall-through (FWFT) read mode. Used as the local buffer between stream producers and consumers inside one clock domain.

Parameters:
Data_Width, 8, data bits per entry
Depth, 256, number of entries; power of two, >= 4
Addr_Width, 8, log2(Depth); must be consistent with Depth
AF_Thresh, 252, almost_full asserts when count >= AF_Thresh (1..Depth)
AE_Thresh, 4, almost_empty asserts when count <= AE_Thresh (0..Depth-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous flush
wr_en  input  1  write request
data_in  input  Data_Width  write data
rd_en  input  1  read request (pop in FWFT mode)
data_out  output  Data_Width  read data
rd_valid  output  1  data_out updated this cycle (standard mode); equals !empty in FWFT mode
full  output  1  count == Depth
empty  output  1  count == 0
almost_full  output  1  count >= AF_Thresh
almost_empty  output  1  count <= AE_Thresh
count  output  Addr_Width+1  current occupancy, 0..Depth
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset is asynchronous on posedge rst. wr_ptr, rd_ptr, count, data_out, rd_valid, overflow and underflow all reset to 0. Resulting flags: empty=1, almost_empty=1, full=0, almost_full=0. Reset mid-operation discards all contents.
- Pointers are Addr_Width+1 bits and wrap naturally. count = wr_ptr - rd_ptr, modulo 2^(Addr_Width+1). All flags are derived from the registered pointers; no combinational path from wr_en or rd_en to any flag.
- Write is accepted iff wr_en && !full. Accepted data is stored at wr_ptr[Addr_Width-1:0] and wr_ptr increments.
- Read is accepted iff rd_en && !empty. rd_ptr increments.
- Full and empty are evaluated on pre-edge state. So:
  - wr_en && rd_en while full: read accepted, write rejected, overflow set.
  - wr_en && rd_en while empty: write accepted, read rejected, underflow set.
  - Otherwise, a simultaneous write and read leaves count unchanged.
- Standard mode (FWFT=0):
  - data_out is registered: the cycle after an accepted read it holds mem[old rd_ptr], and rd_valid pulses for exactly 1 cycle.
  - Read latency is 1 clk.
  - data_out holds its value when no read is accepted.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] as a combinational read of the register array; valid whenever !empty.
  - An accepted read pops the head, and the next entry appears in the same cycle as the pointer update.
  - empty deasserts 1 clk after the first accepted write; data is valid in that same cycle.
- overflow sets on any cycle with wr_en && full. underflow sets on any cycle with rd_en && empty. Both hold until rst or clear.
- clear takes priority over wr_en and rd_en in the same cycle. It zeroes the pointers, count, overflow, underflow, rd_valid and data_out. The following cycle shows empty=1 and count=0.
- Storage contents are not reset; only the pointers define validity.

Test Plan:
- Depth=8, Data_Width=8, FWFT=0, AF_Thresh=6, AE_Thresh=1. Write 0x01..0x08 -> count steps 1..8; almost_empty drops at count=2; almost_full rises at count=6; full at count=8. Read 8 times -> data_out 0x01..0x08, each 1 clk after rd_en with rd_valid high; empty=1 after the last read.
- While full, assert wr_en with 0xAA -> write rejected, overflow=1 and stays high. Read all entries -> 0xAA never appears. Assert clear -> overflow=0, count=0.
- While empty, assert rd_en and wr_en=0x55 together -> underflow=1, count=1. Next read -> data_out=0x55.
- Fill to 4, then simultaneous wr/rd for 20 cycles with incrementing data -> count stays 4, output order is preserved, and the pointers wrap with no data loss.
- FWFT=1: write 0x3C -> the next cycle empty=0 and data_out=0x3C with no rd_en. rd_en for 1 clk -> empty=1.
- Assert rst asynchronously mid-burst, between clk edges -> all outputs go to their reset values immediately. After release, the first write/read pair returns the new data, not stale contents.
